axi_mem_responder: RTL and testbench

AXI4 slave memory model that answers the AXI master ports of the DRAM-side adapter. It stands in for DRAM in simulation and in small FPGA builds, so the DMA controller's DRAM→SRAM path runs against real handshakes. It holds a MEM_WORDS×32-bit array, accepts single and burst reads and writes, and returns B and R responses with IDs. Read and write channels are served by two independent state machines that share the array.

---
 rtl/axi_mem_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model: MEM_WORDS x 32-bit array with independent read and write FSMs.
// Fixed 4-byte transfers, FIXED/INCR bursts, SLVERR for unsupported bursts and WLAST misuse.
module axi_mem_responder #(
    parameter int MEM_WORDS = 4096,
    parameter int RD_WAIT   = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [3:0]  s_axi_awid,
    input  logic [31:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [1:0]  s_axi_awburst,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,

    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,

    output logic [3:0]  s_axi_bid,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,

    input  logic [3:0]  s_axi_arid,
    input  logic [31:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [1:0]  s_axi_arburst,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,

    output logic [3:0]  s_axi_rid,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);

    localparam int         IDX_W       = $clog2(MEM_WORDS);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    // The read register loads one cycle after the wait count starts, so the
    // terminal count is RD_WAIT+1 to land the first beat at AR edge + 2 + RD_WAIT.
    localparam logic [4:0] WAIT_DONE   = 5'(RD_WAIT + 1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    logic [31:0] mem [MEM_WORDS];

    w_state_t         w_state;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_cnt;
    logic             w_fixed;
    logic             w_burst_ok;
    logic             w_err;
    logic             w_hs;
    logic             mem_we;

    r_state_t         r_state;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_cnt;
    logic             r_fixed;
    logic             r_ok;
    logic [4:0]       wait_cnt;

    logic             unused_addr_bits;

    assign unused_addr_bits = ^{s_axi_awaddr[31:IDX_W+2], s_axi_awaddr[1:0],
                                s_axi_araddr[31:IDX_W+2], s_axi_araddr[1:0]};

    assign w_hs   = (w_state == W_DATA) && s_axi_wready && s_axi_wvalid;
    assign mem_we = w_hs && w_burst_ok;

    // Byte-lane writes; the array has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= 4'd0;
            s_axi_bresp   <= RESP_OKAY;
            w_idx         <= '0;
            w_cnt         <= 8'd0;
            w_fixed       <= 1'b0;
            w_burst_ok    <= 1'b0;
            w_err         <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s_axi_awready && s_axi_awvalid) begin
                        s_axi_bid     <= s_axi_awid;
                        w_idx         <= s_axi_awaddr[IDX_W+1:2];
                        w_cnt         <= s_axi_awlen;
                        w_fixed       <= (s_axi_awburst == BURST_FIXED);
                        w_burst_ok    <= (s_axi_awburst == BURST_FIXED) ||
                                         (s_axi_awburst == BURST_INCR);
                        w_err         <= (s_axi_awburst != BURST_FIXED) &&
                                         (s_axi_awburst != BURST_INCR);
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_DATA;
                    end else begin
                        s_axi_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (!w_fixed) begin
                            w_idx <= w_idx + IDX_W'(1);
                        end
                        // The beat count ends the burst; WLAST only feeds the error flag.
                        if (w_cnt == 8'd0) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= (w_err || !s_axi_wlast) ? RESP_SLVERR : RESP_OKAY;
                            w_state      <= W_RESP;
                        end else begin
                            w_cnt <= w_cnt - 8'd1;
                            if (s_axi_wlast) begin
                                w_err <= 1'b1;
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // rdata is the synchronous array read register; it is reloaded on every
    // R handshake so consecutive beats need no bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= 4'd0;
            s_axi_rdata   <= 32'd0;
            s_axi_rresp   <= RESP_OKAY;
            r_idx         <= '0;
            r_cnt         <= 8'd0;
            r_fixed       <= 1'b0;
            r_ok          <= 1'b0;
            wait_cnt      <= 5'd0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axi_arready && s_axi_arvalid) begin
                        s_axi_rid     <= s_axi_arid;
                        r_idx         <= s_axi_araddr[IDX_W+1:2];
                        r_cnt         <= s_axi_arlen;
                        r_fixed       <= (s_axi_arburst == BURST_FIXED);
                        r_ok          <= (s_axi_arburst == BURST_FIXED) ||
                                         (s_axi_arburst == BURST_INCR);
                        wait_cnt      <= 5'd0;
                        s_axi_arready <= 1'b0;
                        r_state       <= R_WAIT;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (wait_cnt == WAIT_DONE) begin
                        s_axi_rdata  <= r_ok ? mem[r_idx] : 32'd0;
                        s_axi_rresp  <= r_ok ? RESP_OKAY : RESP_SLVERR;
                        s_axi_rlast  <= (r_cnt == 8'd0);
                        s_axi_rvalid <= 1'b1;
                        if (!r_fixed) begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                        r_state <= R_DATA;
                    end else begin
                        wait_cnt <= wait_cnt + 5'd1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        if (s_axi_rlast) begin
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            s_axi_rdata <= r_ok ? mem[r_idx] : 32'd0;
                            s_axi_rlast <= (r_cnt == 8'd1);
                            r_cnt       <= r_cnt - 8'd1;
                            if (!r_fixed) begin
                                r_idx <= r_idx + IDX_W'(1);
                            end
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder: directed cases from the test plan plus
// randomized bursts checked against a word-array reference model.
module tb_axi_mem_responder;

    localparam int MEM_WORDS = 4096;
    localparam int RD_WAIT   = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int checks   = 0;
    int failures = 0;

    logic [31:0] modelMem [MEM_WORDS];
    logic [31:0] wrData [256];
    logic [3:0]  wrStrb [256];
    bit          wrLast [256];

    always #5 clk = ~clk;

    axi_mem_responder #(.MEM_WORDS(MEM_WORDS), .RD_WAIT(RD_WAIT)) dut (
        .clk(clk), .reset(reset),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] beatIndex(input logic [31:0] addr, input int beat,
                                              input logic [1:0] burst);
        logic [11:0] base;
        base = addr[13:2];
        return (burst == 2'b00) ? base : base + 12'(beat);
    endfunction

    // Drives one write burst from wrData/wrStrb/wrLast and checks timing and B response.
    task automatic axiWrite(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input bit gaps, output logic [1:0] respSeen);
        bit          ok;
        bit          lastErr;
        bit          hs;
        int          n;
        logic [11:0] idx;
        logic [1:0]  expResp;
        respSeen = 2'bxx;
        ok = (burst == 2'b00) || (burst == 2'b01);
        lastErr = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (wrLast[i] != (i == len)) lastErr = 1'b1;
            if (ok) begin
                idx = beatIndex(addr, i, burst);
                for (int b = 0; b < 4; b++)
                    if (wrStrb[i][b]) modelMem[idx][8*b +: 8] = wrData[i][8*b +: 8];
            end
        end
        expResp = (!ok || lastErr) ? 2'b10 : 2'b00;

        awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
        n = 0;
        do begin hs = awready; waitCycle(); n++; end while (!hs && n < 200);
        awvalid = 1'b0;
        if (!hs) begin checkOutput("aw_timeout", 0, 1); return; end
        checkOutput("awready_after_aw", awready, 1'b0);
        checkOutput("wready_after_aw", wready, 1'b1);

        for (int i = 0; i <= len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                waitCycle();
            end
            wdata = wrData[i]; wstrb = wrStrb[i]; wlast = wrLast[i]; wvalid = 1'b1;
            n = 0;
            do begin hs = wready; waitCycle(); n++; end while (!hs && n < 200);
            if (!hs) begin
                wvalid = 1'b0;
                checkOutput("w_timeout", 0, 1);
                return;
            end
        end
        wvalid = 1'b0; wlast = 1'b0;

        checkOutput("bvalid_at_last_w", bvalid, 1'b1);
        checkOutput("bid", bid, id);
        checkOutput("bresp", bresp, expResp);
        respSeen = bresp;
        repeat ($urandom_range(0, 2)) begin
            waitCycle();
            checkOutput("bvalid_hold", bvalid, 1'b1);
        end
        bready = 1'b1;
        waitCycle();
        bready = 1'b0;
        checkOutput("bvalid_after_b", bvalid, 1'b0);
        checkOutput("awready_after_b", awready, 1'b1);
    endtask

    // Issues one read burst and compares every beat against the model, including stalls.
    task automatic axiRead(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input bit randomReady,
                           input logic [15:0] pat, output logic [31:0] firstData);
        bit          ok;
        bit          hs;
        int          n;
        int          lat;
        int          beat;
        int          cyc;
        logic [31:0] expData;
        firstData = 32'hx;
        ok = (burst == 2'b00) || (burst == 2'b01);
        arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arvalid = 1'b1;
        n = 0;
        do begin hs = arready; waitCycle(); n++; end while (!hs && n < 200);
        arvalid = 1'b0;
        if (!hs) begin checkOutput("ar_timeout", 0, 1); return; end
        checkOutput("arready_after_ar", arready, 1'b0);

        lat = 0;
        while (!rvalid && lat < 100) begin
            waitCycle();
            lat++;
        end
        checkOutput("r_latency", lat, 2 + RD_WAIT);
        if (!rvalid) return;

        beat = 0;
        cyc  = 0;
        while (beat <= len && cyc < 2000) begin
            rready = randomReady ? ($urandom_range(0, 2) != 0) : ((cyc < 16) ? pat[cyc] : 1'b1);
            expData = ok ? modelMem[beatIndex(addr, beat, burst)] : 32'd0;
            checkOutput("rvalid", rvalid, 1'b1);
            if (rvalid !== 1'b1) break;
            checkOutput("rdata", rdata, expData);
            checkOutput("rresp", rresp, ok ? 2'b00 : 2'b10);
            checkOutput("rlast", rlast, (beat == len));
            checkOutput("rid", rid, id);
            if (beat == 0) firstData = rdata;
            hs = rready;
            waitCycle();
            cyc++;
            if (hs) beat++;
        end
        rready = 1'b0;
        checkOutput("r_beats_done", (beat > len), 1'b1);
        checkOutput("rvalid_after_r", rvalid, 1'b0);
        checkOutput("arready_after_r", arready, 1'b1);
    endtask

    task automatic setBeats(input int len, input bit randStrb);
        for (int i = 0; i <= len; i++) begin
            wrData[i] = $urandom;
            wrStrb[i] = randStrb ? 4'($urandom_range(0, 15)) : 4'hF;
            wrLast[i] = (i == len);
        end
    endtask

    // Randomized traffic: mixed bursts, strobes, WLAST misuse, and concurrent read/write.
    task automatic applyStimulus(input int count);
        int          len;
        int          pick;
        logic [1:0]  burst;
        logic [1:0]  resp;
        logic [31:0] data;
        for (int t = 0; t < count; t++) begin
            len  = $urandom_range(0, 15);
            pick = $urandom_range(0, 19);
            burst = (pick < 5) ? 2'b00 : (pick < 17) ? 2'b01 : 2'($urandom_range(2, 3));
            if (t % 5 == 4) begin
                setBeats(len, 1'b1);
                fork
                    axiWrite(4'($urandom), 32'((2048 + $urandom_range(0, 200)) * 4), len,
                             2'b01, 1'b1, resp);
                    axiRead(4'($urandom), 32'($urandom_range(0, 200) * 4),
                            $urandom_range(0, 15), 2'b01, 1'b1, 16'h0, data);
                join
            end else if ($urandom_range(0, 1) == 0) begin
                setBeats(len, 1'b1);
                if ($urandom_range(0, 9) == 0) begin
                    pick = $urandom_range(0, len);
                    wrLast[pick] = !wrLast[pick];
                end
                axiWrite(4'($urandom), $urandom, len, burst, 1'b1, resp);
            end else begin
                axiRead(4'($urandom), $urandom, len, burst, 1'b1, 16'h0, data);
            end
        end
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        bit          hs;
        int          n;

        reset = 1'b0;
        awid = 0; awaddr = 0; awlen = 0; awburst = 0; awvalid = 0;
        wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        arid = 0; araddr = 0; arlen = 0; arburst = 0; arvalid = 0; rready = 0;
        waitCycle();
        waitCycle();
        checkOutput("rst_awready", awready, 0);
        checkOutput("rst_wready", wready, 0);
        checkOutput("rst_bvalid", bvalid, 0);
        checkOutput("rst_arready", arready, 0);
        checkOutput("rst_rvalid", rvalid, 0);
        checkOutput("rst_rlast", rlast, 0);
        checkOutput("rst_bid", bid, 0);
        checkOutput("rst_bresp", bresp, 0);
        checkOutput("rst_rid", rid, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_rresp", rresp, 0);
        reset = 1'b1;
        checkOutput("awready_at_release", awready, 0);
        waitCycle();
        checkOutput("awready_first_edge", awready, 1);
        checkOutput("arready_first_edge", arready, 1);

        // Fill the whole array so every later read has a defined model value.
        for (int k = 0; k < 16; k++) begin
            setBeats(255, 1'b0);
            axiWrite(4'(k), 32'(k * 1024), 255, 2'b01, 1'b0, resp);
        end

        setBeats(0, 1'b0);
        wrData[0] = 32'hDEADBEEF;
        axiWrite(4'h5, 32'h40, 0, 2'b01, 1'b0, resp);
        checkOutput("single_bresp", resp, 2'b00);
        axiRead(4'h6, 32'h40, 0, 2'b01, 1'b0, 16'hFFFF, data);
        checkOutput("single_rdata", data, 32'hDEADBEEF);

        setBeats(3, 1'b0);
        for (int i = 0; i < 4; i++) wrData[i] = 32'(i + 1);
        axiWrite(4'h1, 32'h100, 3, 2'b01, 1'b0, resp);
        axiRead(4'h2, 32'h100, 3, 2'b01, 1'b0, 16'hFFFF, data);
        checkOutput("incr_first", data, 32'd1);

        setBeats(0, 1'b0);
        wrData[0] = 32'h11223344;
        axiWrite(4'h3, 32'h200, 0, 2'b01, 1'b0, resp);
        wrData[0] = 32'hAABBCCDD; wrStrb[0] = 4'b0101;
        axiWrite(4'h3, 32'h200, 0, 2'b01, 1'b0, resp);
        axiRead(4'h3, 32'h200, 0, 2'b01, 1'b0, 16'hFFFF, data);
        checkOutput("strobe_merge", data, 32'h11BB33DD);

        setBeats(1, 1'b0);
        wrData[0] = 32'd7; wrData[1] = 32'd8;
        axiWrite(4'h4, 32'h3FFC, 1, 2'b01, 1'b0, resp);
        axiRead(4'h4, 32'h3FFC, 0, 2'b01, 1'b0, 16'hFFFF, data);
        checkOutput("wrap_top", data, 32'd7);
        axiRead(4'h4, 32'h0000, 0, 2'b01, 1'b0, 16'hFFFF, data);
        checkOutput("wrap_zero", data, 32'd8);
        axiRead(4'h4, 32'h4000, 0, 2'b01, 1'b0, 16'hFFFF, data);
        checkOutput("alias_4000", data, 32'd8);

        setBeats(2, 1'b0);
        wrData[0] = 32'hA; wrData[1] = 32'hB; wrData[2] = 32'hC;
        axiWrite(4'h7, 32'h300, 2, 2'b00, 1'b0, resp);
        axiRead(4'h7, 32'h300, 1, 2'b00, 1'b0, 16'hFFFF, data);
        checkOutput("fixed_last_wins", data, 32'hC);

        setBeats(2, 1'b0);
        wrLast[1] = 1'b1;
        axiWrite(4'h8, 32'h400, 2, 2'b01, 1'b0, resp);
        checkOutput("wlast_early_bresp", resp, 2'b10);
        setBeats(1, 1'b0);
        wrLast[1] = 1'b0;
        axiWrite(4'h8, 32'h410, 1, 2'b01, 1'b0, resp);
        checkOutput("wlast_missing_bresp", resp, 2'b10);
        setBeats(1, 1'b0);
        axiWrite(4'h9, 32'h500, 1, 2'b10, 1'b0, resp);
        checkOutput("bad_awburst_bresp", resp, 2'b10);
        axiRead(4'h9, 32'h500, 1, 2'b01, 1'b0, 16'hFFFF, data);
        axiRead(4'hA, 32'h500, 1, 2'b10, 1'b0, 16'hFFFF, data);
        checkOutput("bad_arburst_rdata", data, 32'd0);

        axiRead(4'hB, 32'h100, 3, 2'b01, 1'b0, 16'b1111_1111_1111_1001, data);

        // Abort a write in W_DATA with reset; no beat has been sent so memory must be intact.
        awid = 4'hC; awaddr = 32'h600; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
        n = 0;
        do begin hs = awready; waitCycle(); n++; end while (!hs && n < 50);
        awvalid = 1'b0;
        checkOutput("rst_test_aw", hs, 1'b1);
        checkOutput("rst_test_in_wdata", wready, 1'b1);
        reset = 1'b0;
        #1;
        checkOutput("rst_mid_wready", wready, 0);
        checkOutput("rst_mid_awready", awready, 0);
        waitCycle();
        waitCycle();
        reset = 1'b1;
        checkOutput("rst_mid_release_awready", awready, 0);
        waitCycle();
        checkOutput("rst_mid_awready_after", awready, 1);
        for (int i = 0; i < 4; i++) begin
            waitCycle();
            checkOutput("rst_mid_no_bvalid", bvalid, 0);
        end
        axiRead(4'hC, 32'h600, 3, 2'b01, 1'b0, 16'hFFFF, data);

        applyStimulus(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        failures++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
